// File: rtl/vga_text_pkg.sv
// Shared text-mode constants: cursor modes and default widths used by video memory and the pixel stage.
package vga_text_pkg;

  typedef logic [1:0] cursor_mode_t;

  localparam cursor_mode_t CURSOR_OFF       = 2'd0;
  localparam cursor_mode_t CURSOR_BLOCK     = 2'd1;
  localparam cursor_mode_t CURSOR_BLINK     = 2'd2;
  localparam cursor_mode_t CURSOR_UNDERLINE = 2'd3;

  localparam int COLOR_BITS_DEF = 3;
  localparam int CHAR_WIDTH_DEF = 8;
  localparam int COL_BITS_DEF   = 7;
  localparam int ROW_BITS_DEF   = 6;

endpackage

// File: rtl/blink_divider.sv
// Frame-counted blink divider: toggles phase every BLINK_FRAMES frame_start pulses.
module blink_divider #(
  parameter int BLINK_FRAMES = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  output logic phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             phase_q, phase_d;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (count_q == LAST) begin
        count_d = '0;
        phase_d = ~phase_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= 1'b1;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/text_pixel_pipeline.sv
// Text-mode pixel output stage: captures one cell row on load and serialises it to the DAC.
// Hardware cursor overlay is built only when TEXT_CURSOR_EN is defined.
module text_pixel_pipeline
  import vga_text_pkg::*;
#(
  parameter int CHAR_WIDTH     = CHAR_WIDTH_DEF,
  parameter int CHAR_LINE_BITS = 4,
  parameter int COLOR_BITS     = COLOR_BITS_DEF,
  parameter int COL_BITS       = COL_BITS_DEF,
  parameter int ROW_BITS       = ROW_BITS_DEF,
  parameter int BLINK_FRAMES   = 24,
  parameter int CURSOR_LINE    = 14,
  parameter int MSB_FIRST      = 0
) (
  input  logic                      clk,
  input  logic                      reset_button,
  input  logic                      load,
  input  logic [CHAR_WIDTH-1:0]     row_pixels,
  input  logic [COLOR_BITS-1:0]     foreground,
  input  logic [COLOR_BITS-1:0]     background,
  input  logic                      blink,
  input  logic                      invert,
  input  logic [COL_BITS-1:0]       cell_x,
  input  logic [ROW_BITS-1:0]       cell_y,
  input  logic [CHAR_LINE_BITS-1:0] cell_line,
  input  logic                      drawing,
  input  logic                      frame_start,
  input  logic [COL_BITS-1:0]       cursor_x,
  input  logic [ROW_BITS-1:0]       cursor_y,
  input  logic [1:0]                cursor_mode,
  output logic [COLOR_BITS-1:0]     dac,
  output logic                      blink_phase
);

  localparam int PIX_W = $clog2(CHAR_WIDTH);
  localparam logic [PIX_W-1:0] P_LAST = PIX_W'(CHAR_WIDTH - 1);

  logic [1:0]            rst_sync_q, rst_sync_d;
  logic                  rst_n;
  logic [CHAR_WIDTH-1:0] pix_q, pix_d;
  logic [COLOR_BITS-1:0] fg_q, fg_d, bg_q, bg_d;
  logic                  blink_q, blink_d, invert_q, invert_d;
  logic [PIX_W-1:0]      p_q, p_d;
  logic [COLOR_BITS-1:0] colour_q, colour_d;
  logic                  drawing_dly_q, drawing_dly_d;
  logic                  glyph;
  logic                  cursor_flip;

  // Reset asserts immediately but releases two clocks after the button goes high.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) rst_sync_q <= '0;
    else               rst_sync_q <= rst_sync_d;
  end
  assign rst_n = rst_sync_q[1];

  blink_divider #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .phase       (blink_phase)
  );

  always_comb begin
    pix_d    = pix_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    blink_d  = blink_q;
    invert_d = invert_q;
    p_d      = p_q;
    if (load) begin
      for (int i = 0; i < CHAR_WIDTH; i++)
        pix_d[i] = (MSB_FIRST != 0) ? row_pixels[CHAR_WIDTH-1-i] : row_pixels[i];
      fg_d     = foreground;
      bg_d     = background;
      blink_d  = blink;
      invert_d = invert;
      p_d      = '0;
    end else if (p_q != P_LAST) begin
      p_d = p_q + 1'b1;
    end
  end

`ifdef TEXT_CURSOR_EN
  logic         cursor_hit_q, cursor_hit_d;
  cursor_mode_t cursor_mode_q, cursor_mode_d;
  logic         line_hit_q, line_hit_d;

  always_comb begin
    cursor_hit_d  = cursor_hit_q;
    cursor_mode_d = cursor_mode_q;
    line_hit_d    = line_hit_q;
    if (load) begin
      cursor_hit_d  = (cell_x == cursor_x) && (cell_y == cursor_y);
      cursor_mode_d = cursor_mode;
      line_hit_d    = (cell_line == CHAR_LINE_BITS'(CURSOR_LINE));
    end
    cursor_flip = 1'b0;
    if (cursor_hit_q) begin
      case (cursor_mode_q)
        CURSOR_BLOCK:     cursor_flip = 1'b1;
        CURSOR_BLINK:     cursor_flip = blink_phase;
        CURSOR_UNDERLINE: cursor_flip = line_hit_q;
        default:          cursor_flip = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_hit_q  <= 1'b0;
      cursor_mode_q <= CURSOR_OFF;
      line_hit_q    <= 1'b0;
    end else begin
      cursor_hit_q  <= cursor_hit_d;
      cursor_mode_q <= cursor_mode_d;
      line_hit_q    <= line_hit_d;
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{cell_x, cell_y, cell_line, cursor_x, cursor_y, cursor_mode};
  assign cursor_flip   = 1'b0;
`endif

  always_comb begin
    glyph = pix_q[p_q] ^ invert_q;
    if (blink_q && !blink_phase) glyph = 1'b0;
    colour_d      = (glyph ^ cursor_flip) ? fg_q : bg_q;
    drawing_dly_d = drawing;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q         <= '0;
      fg_q          <= '0;
      bg_q          <= '0;
      blink_q       <= 1'b0;
      invert_q      <= 1'b0;
      p_q           <= P_LAST;
      colour_q      <= '0;
      drawing_dly_q <= 1'b0;
    end else begin
      pix_q         <= pix_d;
      fg_q          <= fg_d;
      bg_q          <= bg_d;
      blink_q       <= blink_d;
      invert_q      <= invert_d;
      p_q           <= p_d;
      colour_q      <= colour_d;
      drawing_dly_q <= drawing_dly_d;
    end
  end

  // Active-video gate sits after the colour register so it carries one cycle of delay.
  assign dac = drawing_dly_q ? colour_q : '0;

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Self-checking bench for text_pixel_pipeline: cycle-history model plus directed literal pins.
module tb_text_pixel_pipeline;

  localparam int CW   = 8;
  localparam int CB   = 3;
  localparam int XB   = 7;
  localparam int YB   = 6;
  localparam int LB   = 4;
  localparam int BF   = 2;
  localparam int CL   = 14;
  localparam int MSBF = 0;
  localparam int N    = 2048;

  logic          clk = 1'b0;
  logic          reset_button;
  logic          load = 1'b0;
  logic [CW-1:0] row_pixels = '0;
  logic [CB-1:0] foreground = '0, background = '0;
  logic          blink = 1'b0, invert = 1'b0;
  logic [XB-1:0] cell_x = '0, cursor_x = '0;
  logic [YB-1:0] cell_y = '0, cursor_y = '0;
  logic [LB-1:0] cell_line = '0;
  logic          drawing = 1'b1, frame_start = 1'b0;
  logic [1:0]    cursor_mode = 2'd0;
  logic [CB-1:0] dac;
  logic          blink_phase;

  always #5 clk = ~clk;

  text_pixel_pipeline #(
    .CHAR_WIDTH(CW), .CHAR_LINE_BITS(LB), .COLOR_BITS(CB), .COL_BITS(XB), .ROW_BITS(YB),
    .BLINK_FRAMES(BF), .CURSOR_LINE(CL), .MSB_FIRST(MSBF)
  ) dut (
    .clk(clk), .reset_button(reset_button), .load(load), .row_pixels(row_pixels),
    .foreground(foreground), .background(background), .blink(blink), .invert(invert),
    .cell_x(cell_x), .cell_y(cell_y), .cell_line(cell_line), .drawing(drawing),
    .frame_start(frame_start), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .cursor_mode(cursor_mode), .dac(dac), .blink_phase(blink_phase)
  );

  typedef struct {
    logic [CW-1:0] row;
    logic [CB-1:0] fg, bg;
    logic          blk, inv;
    logic [XB-1:0] x, cx;
    logic [YB-1:0] y, cy;
    logic [LB-1:0] line;
    logic [1:0]    mode;
  } cell_t;

  cell_t cell_h [N];
  bit    load_h [N];
  bit    draw_h [N];
  bit    fs_h   [N];
  int    cyc  = 0;
  int    base = 3;
  int    nchk = 0;
  int    nerr = 0;

  // History of inputs per cycle; base is the first cycle the design samples after reset.
  always @(posedge clk) begin
    if (cyc < N) begin
      cell_h[cyc].row  = row_pixels;  cell_h[cyc].fg = foreground; cell_h[cyc].bg = background;
      cell_h[cyc].blk  = blink;       cell_h[cyc].inv = invert;
      cell_h[cyc].x    = cell_x;      cell_h[cyc].y  = cell_y;     cell_h[cyc].line = cell_line;
      cell_h[cyc].cx   = cursor_x;    cell_h[cyc].cy = cursor_y;   cell_h[cyc].mode = cursor_mode;
      load_h[cyc] = load; draw_h[cyc] = drawing; fs_h[cyc] = frame_start;
    end
    if (!reset_button) base = cyc + 3;
    cyc = cyc + 1;
  end

  // Blink phase visible during cycle m: toggles once per BF frame pulses since reset.
  function automatic bit ph(int m);
    int n = 0;
    for (int i = base; i < m; i++) n += int'(fs_h[i]);
    return ((n / BF) % 2) == 0;
  endfunction

  function automatic logic [CB-1:0] exp_dac(int n);
    int    ld = -1;
    int    k;
    bit    g, flip;
    cell_t c;
    if (n - 1 < base) return '0;
    if (!draw_h[n-1]) return '0;
    for (int i = n - 2; i >= base; i--) begin
      if (load_h[i]) begin ld = i; break; end
    end
    if (ld < 0) return '0;
    c = cell_h[ld];
    k = n - 2 - ld;
    if (k > CW - 1) k = CW - 1;
    g = c.row[(MSBF != 0) ? CW - 1 - k : k] ^ c.inv;
    if (c.blk && !ph(n - 1)) g = 1'b0;
    flip = 1'b0;
`ifdef TEXT_CURSOR_EN
    if (c.x == c.cx && c.y == c.cy) begin
      case (c.mode)
        2'd1:    flip = 1'b1;
        2'd2:    flip = ph(n - 1);
        2'd3:    flip = (c.line == LB'(CL));
        default: flip = 1'b0;
      endcase
    end
`endif
    return (g ^ flip) ? c.fg : c.bg;
  endfunction

  task automatic chk(input string nm, input logic [CB-1:0] got, input logic [CB-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_button) begin
      chk("dac_in_reset", dac, '0);
      chk("phase_in_reset", {2'b0, blink_phase}, 3'd1);
    end else begin
      chk($sformatf("dac_c%0d", cyc), dac, exp_dac(cyc));
      chk($sformatf("phase_c%0d", cyc), {2'b0, blink_phase}, {2'b0, ph(cyc)});
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pin(input string nm, input logic [CB-1:0] e);
    @(negedge clk);
    chk(nm, dac, e);
  endtask

  task automatic pin_phase(input string nm, input bit e);
    @(negedge clk);
    chk(nm, {2'b0, blink_phase}, {2'b0, e});
  endtask

  task automatic load_cell(input logic [CW-1:0] r, input logic [CB-1:0] f, input logic [CB-1:0] b,
                           input bit bl, input bit inv, input int x, input int y, input int ln);
    row_pixels = r; foreground = f; background = b; blink = bl; invert = inv;
    cell_x = XB'(x); cell_y = YB'(y); cell_line = LB'(ln);
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  // Pixel k of seq is seq[3k+:3]; call one cycle after the load cycle.
  task automatic chk_seq(input string nm, input logic [8*CB-1:0] seq);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      pin($sformatf("%s_px%0d", nm, k), seq[CB*k +: CB]);
    end
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  localparam logic [23:0] SEQ_T1 = {3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b010};
  localparam logic [2:0]  C_HIT  =
`ifdef TEXT_CURSOR_EN
    3'b101;
`else
    3'b010;
`endif
  localparam logic [2:0]  C_UL14 =
`ifdef TEXT_CURSOR_EN
    3'b010;
`else
    3'b101;
`endif

  initial begin
    reset_button = 1'b1;
    #1 reset_button = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_button = 1'b1;
    step(2);

    // Plain cell, then hold of the last pixel
    load_cell(8'b0000_0101, 3'b010, 3'b001, 0, 0, 0, 0, 0);
    chk_seq("t1", SEQ_T1);
    pin("t1_hold", 3'b001);
    step(1);

    // Inverted cell with a one-cycle drawing gap, then a truncating load
    load_cell(8'b0000_0101, 3'b010, 3'b001, 0, 1, 0, 0, 0);
    step(1);
    pin("t2_px0", 3'b001);
    step(1);
    drawing = 1'b0;
    step(1);
    drawing = 1'b1;
    pin("t2_gap", 3'b000);
    step(1);
    pin("t2_px3", 3'b010);
    step(1);
    load_cell(8'hF0, 3'b110, 3'b011, 0, 0, 0, 0, 0);
    step(1);
    pin("trunc_px0", 3'b011);
    step(4);
    pin("trunc_px4", 3'b110);
    step(1);

    // Blink divider with BLINK_FRAMES=2 on a blinking cell
    load_cell(8'hFF, 3'b111, 3'b100, 1, 0, 0, 0, 0);
    step(3);
    pulse();
    pin_phase("t3_phase_p1", 1'b1);
    step(1);
    pin("t3_on_p1", 3'b111);
    step(1);
    pulse();
    pin_phase("t3_phase_p2", 1'b0);
    step(1);
    pin("t3_off_p2", 3'b100);
    step(1);
    pulse();
    pin_phase("t3_phase_p3", 1'b0);
    step(1);
    pin("t3_off_p3", 3'b100);
    step(1);
    pulse();
    pin_phase("t3_phase_p4", 1'b1);
    step(1);
    pin("t3_on_p4", 3'b111);
    step(1);

    // Block cursor on (5,3), then a neighbouring cell
    cursor_x = 7'd5; cursor_y = 6'd3; cursor_mode = 2'd1;
    load_cell(8'hFF, 3'b010, 3'b101, 0, 0, 5, 3, 0);
    step(1);
    pin("t4_hit_px0", C_HIT);
    step(7);
    pin("t4_hit_px7", C_HIT);
    step(1);
    load_cell(8'hFF, 3'b010, 3'b101, 0, 0, 6, 3, 0);
    step(1);
    pin("t4_miss_px0", 3'b010);
    step(1);

    // Underline cursor on line 14 and line 13, then a blinking-block cell
    cursor_mode = 2'd3;
    load_cell(8'h00, 3'b010, 3'b101, 0, 0, 5, 3, 14);
    step(1);
    pin("t5_line14", C_UL14);
    step(1);
    load_cell(8'h00, 3'b010, 3'b101, 0, 0, 5, 3, 13);
    step(1);
    pin("t5_line13", 3'b101);
    step(1);
    cursor_mode = 2'd2;
    load_cell(8'h00, 3'b010, 3'b101, 0, 0, 5, 3, 0);
    step(4);

    // Mid-cell reset with blink phase low
    pulse();
    step(1);
    pulse();
    load_cell(8'b0000_0101, 3'b010, 3'b001, 0, 0, 0, 0, 0);
    step(3);
    reset_button = 1'b0;
    #1;
    chk("t6_async_dac", dac, 3'b000);
    chk("t6_async_phase", {2'b0, blink_phase}, 3'd1);
    step(2);
    reset_button = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      pin($sformatf("t6_idle%0d", i), 3'b000);
      step(1);
    end
    load_cell(8'b0000_0101, 3'b010, 3'b001, 0, 0, 0, 0, 0);
    chk_seq("t6_reload", SEQ_T1);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/text_pixel_pipeline.md
Name: text_pixel_pipeline

Overview:
Single-clock successor to the text-mode pixel output stage. It captures one character cell's glyph row and attributes on a load strobe, then serialises CHAR_WIDTH pixels to the colour DAC. It applies invert, blink and an optional hardware cursor overlay, and owns its own frame-counted blink divider. It sits between the character generator / video memory and the VGA DAC pins, and replaces the separate per-char clock domain with a load enable.

Parameters:
CHAR_WIDTH, 8, pixels per cell row (2..16)
CHAR_LINE_BITS, 4, width of cell_line (line within the cell)
COLOR_BITS, 3, DAC width per pixel
COL_BITS, 7, text column index width
ROW_BITS, 6, text row index width
BLINK_FRAMES, 24, frames per blink half-period (>=1)
CURSOR_LINE, 14, cell line drawn by the underline cursor
MSB_FIRST, 0, 1 = row_pixels[CHAR_WIDTH-1] is the leftmost pixel; 0 = row_pixels[0] is the leftmost pixel

Ports:
clk  in  1  pixel clock
reset_button  in  1  asynchronous, active-low reset
load  in  1  one-cycle strobe; capture cell data
row_pixels  in  CHAR_WIDTH  glyph row bits
foreground  in  COLOR_BITS  cell foreground colour
background  in  COLOR_BITS  cell background colour
blink  in  1  cell blink attribute
invert  in  1  cell invert attribute
cell_x  in  COL_BITS  column of the cell being loaded
cell_y  in  ROW_BITS  row of the cell being loaded
cell_line  in  CHAR_LINE_BITS  line within the cell being loaded
drawing  in  1  active-video flag, pixel-aligned
frame_start  in  1  one-cycle pulse per frame
cursor_x  in  COL_BITS  cursor column
cursor_y  in  ROW_BITS  cursor row
cursor_mode  in  2  0 off, 1 steady block, 2 blinking block, 3 underline
dac  out  COLOR_BITS  pixel colour
blink_phase  out  1  1 = blinking text visible

Behaviour:
- Reset (asynchronous assert, synchronous release): dac=0, blink_phase=1, blink counter=0, pixel index=CHAR_WIDTH-1, shift/attribute registers=0, drawing_d=0.
- Load at cycle L:
  - Register the row (bit order per MSB_FIRST), fg, bg, blink, invert and cursor_hit.
  - cursor_hit = (cell_x==cursor_x && cell_y==cursor_y).
  - Set pixel index p to 0.
- Each non-load cycle: p increments, saturating at CHAR_WIDTH-1. There is no wrap; a missing load repeats the last pixel.
- Load while p<CHAR_WIDTH-1 truncates the current cell. The new cell takes effect immediately.
- drawing is delayed one register (drawing_d).
- dac is registered. Pixel k of the cell loaded at L appears on dac at cycle L+2+k, gated by drawing sampled at L+1+k. Latency from load to first pixel is 2.
- Pixel colour:
  - glyph = pix[p] ^ invert.
  - If blink && !blink_phase, glyph=0.
  - on = glyph ^ cursor_flip.
  - dac = drawing_d ? (on ? fg : bg) : 0.
- cursor_flip, only when cursor_hit:
  - mode 1: 1.
  - mode 2: blink_phase.
  - mode 3: (captured cell_line == CURSOR_LINE).
  - mode 0: 0.
- Blink divider:
  - On frame_start: if count==BLINK_FRAMES-1, count<=0 and blink_phase toggles; else count increments.
  - frame_start coinciding with load: both take effect; the new blink_phase applies from the following cycle.
- cursor_mode and cursor_x/cursor_y are sampled only at load. Mid-cell changes have no effect.

Optional Feature:
TEXT_CURSOR_EN
- Defined: cursor overlay as specified.
- Undefined: cursor_flip is constant 0, the cursor comparators are not synthesised, and the cursor ports remain but are ignored. All other behaviour is identical.

Decomposition:
- Package vga_text_pkg holds:
  - cursor mode constants CURSOR_OFF, CURSOR_BLOCK, CURSOR_BLINK, CURSOR_UNDERLINE;
  - default COLOR_BITS, CHAR_WIDTH and text column/row widths shared with video memory.
- Sub-module blink_divider (frame_start, count, phase) is natural. It is parameterised by BLINK_FRAMES and is reusable by other overlays.

Test Plan:
1. Reset release, CHAR_WIDTH=8, MSB_FIRST=0, load row 8'b0000_0101, fg=3'b010, bg=3'b001, drawing=1 → dac sequence from L+2: 010,001,010,001,001,001,001,001; then 001 held.
2. Same row with invert=1 → 001,010,001,010,010,010,010,010. With drawing=0 at cycle L+3 → dac=000 at L+4 only.
3. blink=1, BLINK_FRAMES=2: four frame_start pulses → blink_phase 1,0,0,1 toggling after pulses 2 and 4; while phase=0 the whole cell shows bg.
4. TEXT_CURSOR_EN, cursor at (5,3), mode 1, load cell (5,3) row 8'hFF → all 8 pixels bg. Load cell (6,3) → all fg.
5. Mode 3, CURSOR_LINE=14: load cell_line=14 on the cursor cell, row 8'h00 → all fg; cell_line=13 → all bg.
6. Assert reset_button low at L+4 mid-cell → dac=000 and blink_phase=1 asynchronously. After release, no output until the next load.
